// File: rtl/tag_arbiter_sa.sv
// rtl/tag_arbiter_sa.sv - set-associative tag store and miss controller
//
// Tracks valid/tag (and optionally dirty) bits for WAY_NUM ways per set,
// resolves hits combinationally and sequences write-back and refill with the BIU.
//
// Ports:
//   clk, rst                           clock; synchronous active-low reset
//   entry_read/entry_wthru/entry_wback core access strobes
//   address_tag, address_set           access address
//   valid_clear, flush_all             line / cache invalidation (IDLE only)
//   line_refill, writeback_ok          BIU completion strobes
//   line_hit, line_miss, replace_dirty core/BIU status
//   busy                               controller not IDLE, core stalls
//   entry_way_sel                      hit way in IDLE, captured victim way otherwise
//   victim_tag                         old tag of the captured victim
module tag_arbiter_sa #(
    parameter int SET_NUM      = 16,
    parameter int SETSEL_WID   = (SET_NUM > 1) ? $clog2(SET_NUM) : 1,
    parameter int WAY_NUM      = 4,
    parameter int WAYSEL_WID   = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
    parameter int TAG_WID      = 14,
    parameter bit WBACK_ENABLE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  entry_read,
    input  logic                  entry_wthru,
    input  logic                  entry_wback,
    input  logic [TAG_WID-1:0]    address_tag,
    input  logic [SETSEL_WID-1:0] address_set,
    input  logic                  valid_clear,
    input  logic                  flush_all,
    input  logic                  line_refill,
    input  logic                  writeback_ok,
    output logic                  line_hit,
    output logic                  line_miss,
    output logic                  replace_dirty,
    output logic                  busy,
    output logic [WAYSEL_WID-1:0] entry_way_sel,
    output logic [TAG_WID-1:0]    victim_tag
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WBACK  = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WAY_NUM-1:0]    valid_q [SET_NUM];
    logic [WAY_NUM-1:0]    valid_d [SET_NUM];
    logic [WAY_NUM-1:0]    dirty_q [SET_NUM];
    logic [WAY_NUM-1:0]    dirty_d [SET_NUM];
    logic [WAYSEL_WID-1:0] rr_q    [SET_NUM];
    logic [WAYSEL_WID-1:0] rr_d    [SET_NUM];

    // Tag RAM: not reset, written only when a refill completes.
    logic [TAG_WID-1:0]    tag_q   [SET_NUM][WAY_NUM];
    logic                  tag_we;

    // Miss context captured on the IDLE -> WBACK/REFILL transition.
    logic [SETSEL_WID-1:0] set_q, set_d;
    logic [TAG_WID-1:0]    ctag_q, ctag_d;
    logic [TAG_WID-1:0]    vtag_q, vtag_d;
    logic [WAYSEL_WID-1:0] way_q, way_d;
    logic                  from_rr_q, from_rr_d;

    logic                  access;
    logic                  hit;
    logic [WAYSEL_WID-1:0] hit_way;
    logic                  inv_found;
    logic [WAYSEL_WID-1:0] inv_way;
    logic [WAYSEL_WID-1:0] victim_way;
    logic                  victim_dirty;
    logic [WAYSEL_WID-1:0] rr_next;

    assign access = entry_read | entry_wthru | entry_wback;

    // Descending scan so the lowest-index match / invalid way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (valid_q[address_set][w] && (tag_q[address_set][w] == address_tag)) begin
                hit     = 1'b1;
                hit_way = WAYSEL_WID'(w);
            end
            if (!valid_q[address_set][w]) begin
                inv_found = 1'b1;
                inv_way   = WAYSEL_WID'(w);
            end
        end
    end

    assign victim_way   = inv_found ? inv_way : rr_q[address_set];
    assign victim_dirty = WBACK_ENABLE && valid_q[address_set][victim_way]
                          && dirty_q[address_set][victim_way];

    // Round-robin pointer wraps at WAY_NUM-1 so non-power-of-2 way counts work.
    assign rr_next = (rr_q[set_q] == WAYSEL_WID'(WAY_NUM - 1)) ? '0 : rr_q[set_q] + 1'b1;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        rr_d      = rr_q;
        set_d     = set_q;
        ctag_d    = ctag_q;
        vtag_d    = vtag_q;
        way_d     = way_q;
        from_rr_d = from_rr_q;
        tag_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush_all) begin
                    for (int s = 0; s < SET_NUM; s++) begin
                        valid_d[s] = '0;
                        dirty_d[s] = '0;
                    end
                end else if (valid_clear) begin
                    if (hit) begin
                        valid_d[address_set][hit_way] = 1'b0;
                        dirty_d[address_set][hit_way] = 1'b0;
                    end
                end else if (access) begin
                    if (hit) begin
                        if (entry_wback) begin
                            dirty_d[address_set][hit_way] = 1'b1;
                        end
                    end else begin
                        set_d     = address_set;
                        ctag_d    = address_tag;
                        way_d     = victim_way;
                        vtag_d    = tag_q[address_set][victim_way];
                        from_rr_d = !inv_found;
                        state_d   = victim_dirty ? S_WBACK : S_REFILL;
                    end
                end
            end
            S_WBACK: begin
                // writeback_ok wins over a simultaneous line_refill.
                if (writeback_ok) begin
                    dirty_d[set_q][way_q] = 1'b0;
                    state_d               = S_REFILL;
                end
            end
            S_REFILL: begin
                if (line_refill) begin
                    tag_we                = 1'b1;
                    valid_d[set_q][way_q] = 1'b1;
                    dirty_d[set_q][way_q] = 1'b0;
                    if (from_rr_q) begin
                        rr_d[set_q] = rr_next;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!WBACK_ENABLE) begin
            for (int s = 0; s < SET_NUM; s++) begin
                dirty_d[s] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            set_q     <= '0;
            ctag_q    <= '0;
            vtag_q    <= '0;
            way_q     <= '0;
            from_rr_q <= 1'b0;
            for (int s = 0; s < SET_NUM; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            ctag_q    <= ctag_d;
            vtag_q    <= vtag_d;
            way_q     <= way_d;
            from_rr_q <= from_rr_d;
            for (int s = 0; s < SET_NUM; s++) begin
                valid_q[s] <= valid_d[s];
                dirty_q[s] <= dirty_d[s];
                rr_q[s]    <= rr_d[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && tag_we) begin
            tag_q[set_q][way_q] <= ctag_q;
        end
    end

    assign line_hit      = access & hit & (state_q == S_IDLE);
    assign line_miss     = (state_q != S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign replace_dirty = WBACK_ENABLE && (state_q == S_WBACK);
    assign entry_way_sel = (state_q == S_IDLE) ? hit_way : way_q;
    assign victim_tag    = vtag_q;

endmodule
